core_decode: RTL and testbench
==============================

Name: core_decode

Overview:
- Decode/operand-fetch stage directly upstream of the core ALU.
- Accepts one 16-bit TOY instruction per cycle from fetch and reads the 16x16 register file (R0 reads zero).
- Issues a registered bundle of ALU opcode, operands, destination and control class to the execute stage.
- Tracks in-flight register writes with a scoreboard, stalls on hazards and enters a sticky HALTED state on opcode 0.

Parameters:
- NREG, 16, register count; fixed to match the 4-bit register fields.
- XLEN, 16, data width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- inst_valid_i  in  1  fetch offers an instruction.
- inst_ready_o  out  1  decode accepts (combinational).
- inst_i  in  16  instruction word: op[15:12] d[11:8] s[7:4] t[3:0], addr[7:0].
- pc_i  in  8  address of inst_i.
- wb_en_i  in  1  writeback strobe.
- wb_addr_i  in  4  writeback register.
- wb_data_i  in  16  writeback data.
- issue_valid_o  out  1  bundle valid.
- issue_ready_i  in  1  execute consumes the bundle.
- alu_op_o  out  3  0 add, 1 sub, 2 and, 3 xor, 4 shl, 5 shr, 6 pass a, 7 pass b.
- a_o  out  16  ALU operand a.
- b_o  out  16  ALU operand b.
- st_data_o  out  16  R[d] for stores.
- rd_o  out  4  destination register.
- rd_we_o  out  1  destination written.
- class_o  out  3  ALU, LOAD, STORE, BRZ, BRP, JUMP, HALT (encoding in package).
- target_o  out  8  branch/jump target.
- halted_o  out  1  machine halted.

Behaviour:
- Reset (async assert, sync release):
  - issue_valid_o=0.
  - All bundle outputs 0.
  - Scoreboard cleared.
  - Register file cleared.
  - halted_o=0.
  - FSM = RUN.
- FSM states:
  - RUN -> HALTED when opcode 0 is accepted.
  - HALTED is left only by reset.
  - In HALTED: inst_ready_o=0. Writeback and draining of the issued HALT bundle continue.
- Accept condition, inst_valid_i && inst_ready_o, where inst_ready_o = RUN && !hazard && (!issue_valid_o || issue_ready_i).
- Latency: accepted instruction appears on the bundle the next cycle. Bundle holds stable while issue_valid_o && !issue_ready_i.
- Decode (ZX = zero-extend):

| Opcode | Operation | alu_op | a / b | Other outputs |
|---|---|---|---|---|
| 1–6 | RR op | op-1 | a=R[s], b=R[t] | rd=d, we=1 |
| 7 | load address | 7 | b=ZX(addr) | we=1 |
| 8 | load | 7 | b=ZX(addr) | class LOAD, we=1 |
| 9 | store | 7 | b=ZX(addr) | class STORE, st_data=R[d], we=0 |
| A | load indirect | 7 | b=R[t] | class LOAD, we=1 |
| B | store indirect | 7 | b=R[t] | class STORE, st_data=R[d] |
| C | branch if zero | 6 | a=R[d] | class BRZ, target=addr |
| D | branch if positive | 6 | a=R[d] | class BRP, target=addr |
| E | jump register | 6 | a=R[d] | class JUMP, target=R[d][7:0] |
| F | jump and link | 6 | a=ZX(pc_i+1), 8-bit wrap | class JUMP, target=addr, we=1 |
| 0 | halt | — | — | class HALT, we=0 |

- Register-number and operand rules:
  - Any instruction with rd_we=1 and d=0 issues rd_we_o=0.
  - Any read of R0 returns 0.
  - Unused operands are 0.
- Register file:
  - Written on wb_en_i with wb_addr_i!=0.
  - A read of the register being written in the same cycle returns wb_data_i (bypass).
- Scoreboard: pending[15:0].
  - On accept with effective rd_we, set pending[d].
  - On wb_en_i, clear pending[wb_addr_i].
  - If both hit the same register in one cycle, the set wins.
- hazard: asserted when any register read by the incoming instruction, or its destination (WAW), is pending and is not being cleared by writeback this cycle.
  - Sources: 1–6 s,t; 9 d; A t; B t,d; C/D/E d.
  - hazard is 0 when inst_valid_i=0.
- Simultaneous consume and accept: the bundle is replaced with no bubble.
- Reset mid-stall: pending instructions are discarded and fetch must re-present them.

Decomposition:
- core_pkg (shared): opcode constants, alu_op_e (8 values listed above), class_e, XLEN.
- Sub-module core_regfile: 16x16 storage, 2 read ports plus the st_data read, write port, R0 zero, write-to-read bypass.
- Scoreboard and FSM stay in core_decode.

Test Plan:
- Accept 0x1123 with R2=5, R3=7, issue_ready_i=1 -> next cycle issue_valid=1, alu_op=0, a=5, b=7, rd=1, rd_we=1, pending[1]=1.
- Accept 0x1123 then 0x2412 back-to-back with no writeback -> second instruction stalls with inst_ready_o=0. Then wb R1=0x000C -> same cycle ready=1, issues a=0x000C.
- Accept 0xF0FF at pc_i=0xFF -> rd_we_o=0 (d=0), a=0x0000 (pc wrap), target=0xFF, class JUMP.
- Hold issue_ready_i=0 for 3 cycles after 0x7A42 -> bundle stable (b=0x0042, rd=A), inst_ready_o=0. Release -> next instruction accepted in the same cycle.
- Accept 0x0000 -> class HALT issued, halted_o=1, inst_ready_o stays 0 for 10 cycles with inst_valid_i=1. Assert rst_ni=0 -> all outputs 0 immediately.
- wb R5=0x1234 in the same cycle as accepting 0x9500 -> st_data_o=0x1234 via bypass, b=0x0000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the TOY decode/operand-fetch stage.
package core_pkg;

   localparam int unsigned XLEN = 16;
   localparam int unsigned NREG = 16;

   localparam logic [3:0] OpHalt  = 4'h0;
   localparam logic [3:0] OpLa    = 4'h7;
   localparam logic [3:0] OpLd    = 4'h8;
   localparam logic [3:0] OpSt    = 4'h9;
   localparam logic [3:0] OpLdi   = 4'hA;
   localparam logic [3:0] OpSti   = 4'hB;
   localparam logic [3:0] OpBrz   = 4'hC;
   localparam logic [3:0] OpBrp   = 4'hD;
   localparam logic [3:0] OpJr    = 4'hE;
   localparam logic [3:0] OpJal   = 4'hF;

   typedef enum logic [2:0] {
      AluAdd, AluSub, AluAnd, AluXor, AluShl, AluShr, AluPassA, AluPassB
   } alu_op_e;

   typedef enum logic [2:0] {
      ClsAlu, ClsLoad, ClsStore, ClsBrz, ClsBrp, ClsJump, ClsHalt
   } class_e;

   typedef enum logic {StRun, StHalted} state_e;

   typedef struct packed {
      alu_op_e         alu_op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] st_data;
      logic [3:0]      rd;
      logic            rd_we;
      class_e          cls;
      logic [7:0]      target;
   } bundle_t;

endpackage

// File: rtl/core_regfile.sv
// 16x16 register file: three read ports, one write port, R0 hard-wired to zero,
// same-cycle write-to-read bypass.
module core_regfile
   import core_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            wb_en_i,
   input  logic [3:0]      wb_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic [3:0]      ra_addr_i,
   output logic [XLEN-1:0] ra_data_o,
   input  logic [3:0]      rb_addr_i,
   output logic [XLEN-1:0] rb_data_o,
   input  logic [3:0]      rc_addr_i,
   output logic [XLEN-1:0] rc_data_o
);

   logic [XLEN-1:0] mem_q [NREG];
   logic            wr_en;

   assign wr_en = wb_en_i && (wb_addr_i != 4'd0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NREG); i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wb_addr_i] <= wb_data_i;
      end
   end

   function automatic logic [XLEN-1:0] rd_port(input logic [3:0] addr,
                                               input logic [XLEN-1:0] stored);
      if (addr == 4'd0)                     return '0;
      else if (wr_en && wb_addr_i == addr)  return wb_data_i;
      else                                  return stored;
   endfunction

   assign ra_data_o = rd_port(ra_addr_i, mem_q[ra_addr_i]);
   assign rb_data_o = rd_port(rb_addr_i, mem_q[rb_addr_i]);
   assign rc_data_o = rd_port(rc_addr_i, mem_q[rc_addr_i]);

endmodule

// File: rtl/core_decode.sv
// Decode/operand-fetch stage: decodes TOY instructions, reads operands, tracks
// in-flight writes in a scoreboard and issues a registered bundle to execute.
module core_decode
   import core_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            inst_valid_i,
   output logic            inst_ready_o,
   input  logic [15:0]     inst_i,
   input  logic [7:0]      pc_i,
   input  logic            wb_en_i,
   input  logic [3:0]      wb_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic            issue_valid_o,
   input  logic            issue_ready_i,
   output logic [2:0]      alu_op_o,
   output logic [XLEN-1:0] a_o,
   output logic [XLEN-1:0] b_o,
   output logic [XLEN-1:0] st_data_o,
   output logic [3:0]      rd_o,
   output logic            rd_we_o,
   output logic [2:0]      class_o,
   output logic [7:0]      target_o,
   output logic            halted_o
);

   logic [3:0]      op, fd, fs, ft;
   logic [7:0]      addr, pc_inc;
   logic [XLEN-1:0] s_data, t_data, d_data;
   logic [NREG-1:0] pending_q, pending_d, wb_mask, pend_eff;
   state_e          state_q, state_d;
   bundle_t         bundle_q, bundle_d, dec;
   logic            valid_q, valid_d;
   logic            use_s, use_t, use_d, we_raw, hazard, accept;

   assign op     = inst_i[15:12];
   assign fd     = inst_i[11:8];
   assign fs     = inst_i[7:4];
   assign ft     = inst_i[3:0];
   assign addr   = inst_i[7:0];
   assign pc_inc = pc_i + 8'd1;

   core_regfile u_regfile (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wb_en_i   (wb_en_i),
      .wb_addr_i (wb_addr_i),
      .wb_data_i (wb_data_i),
      .ra_addr_i (fs),
      .ra_data_o (s_data),
      .rb_addr_i (ft),
      .rb_data_o (t_data),
      .rc_addr_i (fd),
      .rc_data_o (d_data)
   );

   always_comb begin
      dec    = '0;
      use_s  = 1'b0;
      use_t  = 1'b0;
      use_d  = 1'b0;
      we_raw = 1'b0;
      unique case (op)
         OpHalt: dec.cls = ClsHalt;
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
            dec.alu_op = alu_op_e'(op[2:0] - 3'd1);
            dec.a      = s_data;
            dec.b      = t_data;
            use_s      = 1'b1;
            use_t      = 1'b1;
            we_raw     = 1'b1;
         end
         OpLa, OpLd: begin
            dec.alu_op = AluPassB;
            dec.b      = {8'h00, addr};
            dec.cls    = (op == OpLd) ? ClsLoad : ClsAlu;
            we_raw     = 1'b1;
         end
         OpSt: begin
            dec.alu_op  = AluPassB;
            dec.b       = {8'h00, addr};
            dec.st_data = d_data;
            dec.cls     = ClsStore;
            use_d       = 1'b1;
         end
         OpLdi: begin
            dec.alu_op = AluPassB;
            dec.b      = t_data;
            dec.cls    = ClsLoad;
            use_t      = 1'b1;
            we_raw     = 1'b1;
         end
         OpSti: begin
            dec.alu_op  = AluPassB;
            dec.b       = t_data;
            dec.st_data = d_data;
            dec.cls     = ClsStore;
            use_t       = 1'b1;
            use_d       = 1'b1;
         end
         OpBrz, OpBrp: begin
            dec.alu_op = AluPassA;
            dec.a      = d_data;
            dec.cls    = (op == OpBrz) ? ClsBrz : ClsBrp;
            dec.target = addr;
            use_d      = 1'b1;
         end
         OpJr: begin
            dec.alu_op = AluPassA;
            dec.a      = d_data;
            dec.cls    = ClsJump;
            dec.target = d_data[7:0];
            use_d      = 1'b1;
         end
         OpJal: begin
            dec.alu_op = AluPassA;
            dec.a      = {8'h00, pc_inc};
            dec.cls    = ClsJump;
            dec.target = addr;
            we_raw     = 1'b1;
         end
         default: ;
      endcase
      dec.rd_we = we_raw && (fd != 4'd0);
      dec.rd    = dec.rd_we ? fd : 4'd0;
   end

   // A register being written back this cycle no longer blocks the reader.
   assign wb_mask  = wb_en_i ? ({{(NREG-1){1'b0}}, 1'b1} << wb_addr_i) : '0;
   assign pend_eff = pending_q & ~wb_mask;

   assign hazard = inst_valid_i && ((use_s && pend_eff[fs]) || (use_t && pend_eff[ft]) ||
                                    (use_d && pend_eff[fd]) || (dec.rd_we && pend_eff[fd]));

   assign inst_ready_o = (state_q == StRun) && !hazard && (!valid_q || issue_ready_i);
   assign accept       = inst_valid_i && inst_ready_o;

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      bundle_d  = bundle_q;
      pending_d = pend_eff;
      if (accept) begin
         valid_d  = 1'b1;
         bundle_d = dec;
         if (op == OpHalt) state_d = StHalted;
         if (dec.rd_we) pending_d[fd] = 1'b1;
      end else if (issue_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StRun;
         valid_q   <= 1'b0;
         bundle_q  <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         bundle_q  <= bundle_d;
         pending_q <= pending_d;
      end
   end

   assign issue_valid_o = valid_q;
   assign alu_op_o      = bundle_q.alu_op;
   assign a_o           = bundle_q.a;
   assign b_o           = bundle_q.b;
   assign st_data_o     = bundle_q.st_data;
   assign rd_o          = bundle_q.rd;
   assign rd_we_o       = bundle_q.rd_we;
   assign class_o       = bundle_q.cls;
   assign target_o      = bundle_q.target;
   assign halted_o      = (state_q == StHalted);

endmodule

// File: tb/tb_core_decode.sv
// Directed bench for core_decode: decode table plus stall, backpressure and halt sequences.
module tb_core_decode;

   typedef struct packed {
      logic [15:0] inst;
      logic [7:0]  pc;
      logic        wb_en;
      logic [3:0]  wb_addr;
      logic [15:0] wb_data;
      logic [2:0]  alu;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] st;
      logic [3:0]  rd;
      logic        we;
      logic [2:0]  cls;
      logic [7:0]  tgt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        inst_valid = 1'b0;
   logic        inst_ready;
   logic [15:0] inst = '0;
   logic [7:0]  pc = '0;
   logic        wb_en = 1'b0;
   logic [3:0]  wb_addr = '0;
   logic [15:0] wb_data = '0;
   logic        issue_valid;
   logic        issue_ready = 1'b1;
   logic [2:0]  alu_op;
   logic [15:0] a, b, st_data;
   logic [3:0]  rd;
   logic        rd_we;
   logic [2:0]  cls;
   logic [7:0]  target;
   logic        halted;

   int total = 0;
   int bad   = 0;
   vec_t vecs[18];

   always #5 clk = ~clk;

   core_decode dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .inst_valid_i  (inst_valid),
      .inst_ready_o  (inst_ready),
      .inst_i        (inst),
      .pc_i          (pc),
      .wb_en_i       (wb_en),
      .wb_addr_i     (wb_addr),
      .wb_data_i     (wb_data),
      .issue_valid_o (issue_valid),
      .issue_ready_i (issue_ready),
      .alu_op_o      (alu_op),
      .a_o           (a),
      .b_o           (b),
      .st_data_o     (st_data),
      .rd_o          (rd),
      .rd_we_o       (rd_we),
      .class_o       (cls),
      .target_o      (target),
      .halted_o      (halted)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_bundle(input string nm, input vec_t v);
      chk({nm, ".valid"}, 32'(issue_valid), 32'd1);
      chk({nm, ".alu"},   32'(alu_op),  32'(v.alu));
      chk({nm, ".a"},     32'(a),       32'(v.a));
      chk({nm, ".b"},     32'(b),       32'(v.b));
      chk({nm, ".st"},    32'(st_data), 32'(v.st));
      chk({nm, ".rd"},    32'(rd),      32'(v.rd));
      chk({nm, ".we"},    32'(rd_we),   32'(v.we));
      chk({nm, ".cls"},   32'(cls),     32'(v.cls));
      chk({nm, ".tgt"},   32'(target),  32'(v.tgt));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".valid"},  32'(issue_valid), 32'd0);
      chk({nm, ".bundle"}, {a, b}, 32'd0);
      chk({nm, ".misc"},   {st_data, 2'b0, rd, rd_we, alu_op, cls, halted}, 32'd0);
      chk({nm, ".tgt"},    32'(target), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ni = 1'b0; inst_valid = 1'b0; wb_en = 1'b0; issue_ready = 1'b1;
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic wb_write(input logic [3:0] ad, input logic [15:0] d);
      @(negedge clk);
      wb_en = 1'b1; wb_addr = ad; wb_data = d;
      @(posedge clk);
      #1 wb_en = 1'b0;
   endtask

   initial begin
      //          inst     pc     wb  wa    wd        alu   a         b         st        rd    we    cls   tgt
      vecs[0]  = '{16'h1823, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd0, 16'h0005, 16'h0007, 16'h0000, 4'h8, 1'b1, 3'd0, 8'h00};
      vecs[1]  = '{16'h2934, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd1, 16'h0007, 16'h0100, 16'h0000, 4'h9, 1'b1, 3'd0, 8'h00};
      vecs[2]  = '{16'h3A62, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd2, 16'hFFF0, 16'h0005, 16'h0000, 4'hA, 1'b1, 3'd0, 8'h00};
      vecs[3]  = '{16'h4B67, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd3, 16'hFFF0, 16'h00AB, 16'h0000, 4'hB, 1'b1, 3'd0, 8'h00};
      vecs[4]  = '{16'h5C02, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd4, 16'h0000, 16'h0005, 16'h0000, 4'hC, 1'b1, 3'd0, 8'h00};
      vecs[5]  = '{16'h6D74, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd5, 16'h00AB, 16'h0100, 16'h0000, 4'hD, 1'b1, 3'd0, 8'h00};
      vecs[6]  = '{16'h7E42, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd7, 16'h0000, 16'h0042, 16'h0000, 4'hE, 1'b1, 3'd0, 8'h00};
      vecs[7]  = '{16'h8F99, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd7, 16'h0000, 16'h0099, 16'h0000, 4'hF, 1'b1, 3'd1, 8'h00};
      vecs[8]  = '{16'h9700, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd7, 16'h0000, 16'h0000, 16'h00AB, 4'h0, 1'b0, 3'd2, 8'h00};
      vecs[9]  = '{16'hA123, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd7, 16'h0000, 16'h0007, 16'h0000, 4'h1, 1'b1, 3'd1, 8'h00};
      vecs[10] = '{16'hB624, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd7, 16'h0000, 16'h0100, 16'hFFF0, 4'h0, 1'b0, 3'd2, 8'h00};
      vecs[11] = '{16'hC355, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd6, 16'h0007, 16'h0000, 16'h0000, 4'h0, 1'b0, 3'd3, 8'h55};
      vecs[12] = '{16'hD655, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd6, 16'hFFF0, 16'h0000, 16'h0000, 4'h0, 1'b0, 3'd4, 8'h55};
      vecs[13] = '{16'hE700, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd6, 16'h00AB, 16'h0000, 16'h0000, 4'h0, 1'b0, 3'd5, 8'hAB};
      vecs[14] = '{16'hF03C, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd6, 16'h0011, 16'h0000, 16'h0000, 4'h0, 1'b0, 3'd5, 8'h3C};
      vecs[15] = '{16'hF0FF, 8'hFF, 1'b0, 4'h0, 16'h0000, 3'd6, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 3'd5, 8'hFF};
      vecs[16] = '{16'h1023, 8'h10, 1'b0, 4'h0, 16'h0000, 3'd0, 16'h0005, 16'h0007, 16'h0000, 4'h0, 1'b0, 3'd0, 8'h00};
      vecs[17] = '{16'h9500, 8'h10, 1'b1, 4'h5, 16'h1234, 3'd7, 16'h0000, 16'h0000, 16'h1234, 4'h0, 1'b0, 3'd2, 8'h00};

      // Reset state and decode table
      do_reset();
      #1 chk_zero("reset");
      chk("reset.ready", 32'(inst_ready), 32'd1);
      wb_write(4'h2, 16'h0005);
      wb_write(4'h3, 16'h0007);
      wb_write(4'h4, 16'h0100);
      wb_write(4'h6, 16'hFFF0);
      wb_write(4'h7, 16'h00AB);
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         inst = vecs[i].inst; pc = vecs[i].pc; inst_valid = 1'b1;
         wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
         #1 chk($sformatf("vec%0d.ready", i), 32'(inst_ready), 32'd1);
         @(posedge clk);
         #1 wb_en = 1'b0; inst_valid = 1'b0;
         chk_bundle($sformatf("vec%0d", i), vecs[i]);
      end

      // RAW hazard on R1, released by same-cycle writeback
      do_reset();
      wb_write(4'h2, 16'h0005);
      wb_write(4'h3, 16'h0007);
      @(negedge clk);
      inst = 16'h1123; inst_valid = 1'b1;
      @(posedge clk);
      #1 chk_bundle("raw.first", '{16'h1123, 8'h0, 1'b0, 4'h0, 16'h0, 3'd0, 16'h5, 16'h7,
                                   16'h0, 4'h1, 1'b1, 3'd0, 8'h0});
      @(negedge clk);
      inst = 16'h2412;
      #1 chk("raw.stall0", 32'(inst_ready), 32'd0);
      @(posedge clk);
      #1 chk("raw.bubble", 32'(issue_valid), 32'd0);
      @(negedge clk);
      #1 chk("raw.stall1", 32'(inst_ready), 32'd0);
      wb_en = 1'b1; wb_addr = 4'h1; wb_data = 16'h000C;
      #1 chk("raw.release", 32'(inst_ready), 32'd1);
      @(posedge clk);
      #1 wb_en = 1'b0; inst_valid = 1'b0;
      chk_bundle("raw.second", '{16'h2412, 8'h0, 1'b0, 4'h0, 16'h0, 3'd1, 16'h000C, 16'h5,
                                 16'h0, 4'h4, 1'b1, 3'd0, 8'h0});

      // Backpressure holds the bundle; release accepts with no bubble
      do_reset();
      wb_write(4'h2, 16'h0005);
      wb_write(4'h3, 16'h0007);
      @(negedge clk);
      inst = 16'h7A42; inst_valid = 1'b1;
      @(posedge clk);
      #1 issue_ready = 1'b0; inst = 16'h1823;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 chk($sformatf("bp%0d.ready", k), 32'(inst_ready), 32'd0);
         chk_bundle($sformatf("bp%0d", k), '{16'h7A42, 8'h0, 1'b0, 4'h0, 16'h0, 3'd7, 16'h0,
                                            16'h0042, 16'h0, 4'hA, 1'b1, 3'd0, 8'h0});
      end
      issue_ready = 1'b1;
      #1 chk("bp.release", 32'(inst_ready), 32'd1);
      @(posedge clk);
      #1 inst_valid = 1'b0;
      chk_bundle("bp.next", vecs[0]);

      // Halt is sticky until reset; reset clears outputs asynchronously
      do_reset();
      @(negedge clk);
      inst = 16'h0000; inst_valid = 1'b1;
      #1 chk("halt.ready", 32'(inst_ready), 32'd1);
      @(posedge clk);
      #1 chk("halt.valid", 32'(issue_valid), 32'd1);
      chk("halt.cls", 32'(cls), 32'd6);
      chk("halt.we", 32'(rd_we), 32'd0);
      chk("halt.halted", 32'(halted), 32'd1);
      inst = 16'h1823;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1 chk($sformatf("halt%0d.ready", k), 32'(inst_ready), 32'd0);
      end
      chk("halt.drained", 32'(issue_valid), 32'd0);
      chk("halt.sticky", 32'(halted), 32'd1);
      #2 rst_ni = 1'b0;
      #1 chk_zero("async_reset");
      inst_valid = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
